// File: rtl/my_cpu_core_pkg.sv
// Shared definitions for my_cpu_core: FSM encoding, opcode and ALU function codes.
package my_cpu_core_pkg;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_WB    = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  localparam logic [3:0] OP_ALU  = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0001;
  localparam logic [3:0] OP_JZ   = 4'b0010;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [3:0] FN_ADD = 4'b1010;
  localparam logic [3:0] FN_SUB = 4'b0010;
  localparam logic [3:0] FN_AND = 4'b1100;
  localparam logic [3:0] FN_OR  = 4'b1110;
  localparam logic [3:0] FN_XOR = 4'b1101;
  localparam logic [3:0] FN_NOT = 4'b1011;

  // Bit positions inside the {N, C, Z} flag vector.
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 0;

endpackage

// File: rtl/my_cpu_core_alu.sv
// Combinational ALU for my_cpu_core; the only arithmetic/logic in the core.
module my_alu_p
  import my_cpu_core_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       func,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             valid_func
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  // SUB carry is "no borrow", i.e. a >= b unsigned.
  always_comb begin
    result     = '0;
    carry      = 1'b0;
    valid_func = 1'b1;
    case (func)
      FN_ADD: begin result = sum[WIDTH-1:0];  carry = sum[WIDTH];   end
      FN_SUB: begin result = diff[WIDTH-1:0]; carry = ~diff[WIDTH]; end
      FN_AND: result = a & b;
      FN_OR:  result = a | b;
      FN_XOR: result = a ^ b;
      FN_NOT: result = ~a;
      default: valid_func = 1'b0;
    endcase
  end

endmodule

// File: rtl/my_cpu_core.sv
// Multi-cycle 16-bit-instruction core: FETCH/EXEC/WB sequencer, PC, 16-entry register file.
//   state   | meaning
//   S_FETCH | imem_req high at PC, wait for imem_ack, latch IR
//   S_EXEC  | decode IR, capture ALU result/flags/write enables
//   S_WB    | commit register/flags, advance or load PC
//   S_HALT  | parked until RST
module my_cpu_core
  import my_cpu_core_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int PC_W  = 8
) (
  input  logic             CK,
  input  logic             RST,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [15:0]      imem_data,
  input  logic [3:0]       dbg_sel,
  output logic [WIDTH-1:0] dbg_data,
  output logic [2:0]       flags,
  output logic             illegal,
  output logic             halted
);

  state_e           state_q;
  logic [PC_W-1:0]  pc_q;
  logic [15:0]      ir_q;
  logic [WIDTH-1:0] rf_q [16];
  logic [2:0]       flags_q;
  logic [WIDTH-1:0] res_q;
  logic [2:0]       flg_res_q;
  logic             wr_q, setf_q, jmp_q, halt_q;
  logic             illegal_q, halted_q;

  logic [3:0]       op, fn, rd, rs;
  logic [WIDTH-1:0] alu_a, alu_b, alu_res;
  logic [3:0]       alu_fn;
  logic             alu_carry, alu_valid;
  logic             wr_d, setf_d, jmp_d, halt_d, ill_d;
  logic [2:0]       flags_d;

  assign op = ir_q[15:12];
  assign rd = ir_q[11:8];
  assign fn = ir_q[7:4];
  assign rs = ir_q[3:0];

  // ADDI reuses the ALU adder with a sign-extended immediate.
  assign alu_a  = rf_q[rd];
  assign alu_b  = (op == OP_ADDI) ? WIDTH'($signed(ir_q[7:0])) : rf_q[rs];
  assign alu_fn = (op == OP_ADDI) ? FN_ADD : fn;

  my_alu_p #(.WIDTH(WIDTH)) u_alu (
    .a          (alu_a),
    .b          (alu_b),
    .func       (alu_fn),
    .result     (alu_res),
    .carry      (alu_carry),
    .valid_func (alu_valid)
  );

  assign flags_d = {alu_res[WIDTH-1], alu_carry, (alu_res == '0)};

  always_comb begin
    wr_d   = 1'b0;
    setf_d = 1'b0;
    jmp_d  = 1'b0;
    halt_d = 1'b0;
    ill_d  = 1'b0;
    case (op)
      OP_ALU: begin
        wr_d   = alu_valid;
        setf_d = alu_valid;
        ill_d  = ~alu_valid;
      end
      OP_ADDI: begin
        wr_d   = 1'b1;
        setf_d = 1'b1;
      end
      OP_JZ:   jmp_d  = flags_q[FLAG_Z];
      OP_HALT: halt_d = 1'b1;
      default: ill_d  = 1'b1;
    endcase
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q   <= S_FETCH;
      pc_q      <= '0;
      ir_q      <= '0;
      flags_q   <= '0;
      res_q     <= '0;
      flg_res_q <= '0;
      wr_q      <= 1'b0;
      setf_q    <= 1'b0;
      jmp_q     <= 1'b0;
      halt_q    <= 1'b0;
      illegal_q <= 1'b0;
      halted_q  <= 1'b0;
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
    end else begin
      illegal_q <= 1'b0;
      case (state_q)
        S_FETCH: begin
          if (imem_ack) begin
            ir_q    <= imem_data;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          res_q     <= alu_res;
          flg_res_q <= flags_d;
          wr_q      <= wr_d;
          setf_q    <= setf_d;
          jmp_q     <= jmp_d;
          halt_q    <= halt_d;
          illegal_q <= ill_d;
          state_q   <= S_WB;
        end
        S_WB: begin
          if (wr_q)   rf_q[rd] <= res_q;
          if (setf_q) flags_q  <= flg_res_q;
          if (halt_q) begin
            halted_q <= 1'b1;
            state_q  <= S_HALT;
          end else begin
            pc_q    <= jmp_q ? PC_W'(ir_q[7:0]) : pc_q + PC_W'(1);
            state_q <= S_FETCH;
          end
        end
        default: state_q <= S_HALT;
      endcase
    end
  end

  assign imem_req  = (state_q == S_FETCH);
  assign imem_addr = pc_q;
  assign dbg_data  = rf_q[dbg_sel];
  assign flags     = flags_q;
  assign illegal   = illegal_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_my_cpu_core.sv
// Directed bench for my_cpu_core: a 16-bit instance checked against a reference model
// through a scoreboard, and a 32-bit/4-bit-PC instance for wrap and carry corners.
module tb_my_cpu_core;

  logic CK = 1'b0;
  always #5 CK = ~CK;

  logic        rst_a, req_a, ack_a, ill_a, halt_a;
  logic [7:0]  addr_a;
  logic [15:0] data_a, dbg_a;
  logic [3:0]  sel_a;
  logic [2:0]  flags_a;

  logic        rst_b, req_b, ack_b, ill_b, halt_b;
  logic [3:0]  addr_b;
  logic [15:0] data_b;
  logic [31:0] dbg_b;
  logic [3:0]  sel_b;
  logic [2:0]  flags_b;

  my_cpu_core #(.WIDTH(16), .PC_W(8)) dut_a (
    .CK(CK), .RST(rst_a), .imem_req(req_a), .imem_addr(addr_a), .imem_ack(ack_a),
    .imem_data(data_a), .dbg_sel(sel_a), .dbg_data(dbg_a), .flags(flags_a),
    .illegal(ill_a), .halted(halt_a)
  );

  my_cpu_core #(.WIDTH(32), .PC_W(4)) dut_b (
    .CK(CK), .RST(rst_b), .imem_req(req_b), .imem_addr(addr_b), .imem_ack(ack_b),
    .imem_data(data_b), .dbg_sel(sel_b), .dbg_data(dbg_b), .flags(flags_b),
    .illegal(ill_b), .halted(halt_b)
  );

  int vecs = 0;
  int miscomp = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscomp++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  rd;
    logic [15:0] val;
    logic [2:0]  fl;
    logic [7:0]  pc;
    logic        ill;
    logic        hlt;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] m_r [16];
  logic [2:0]  m_fl;
  logic [7:0]  m_pc;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_r[i] = 16'h0;
    m_fl = 3'b000;
    m_pc = 8'h00;
    sb.delete();
  endtask

  task automatic model(input logic [15:0] ins);
    exp_t        e;
    logic [16:0] t;
    logic [15:0] a, b, res;
    logic        c, wr, ill, hlt;
    logic [3:0]  rd;
    rd = ins[11:8];
    a = m_r[rd];
    b = m_r[ins[3:0]];
    res = 16'h0; c = 1'b0; wr = 1'b0; ill = 1'b0; hlt = 1'b0;
    case (ins[15:12])
      4'h0: begin
        wr = 1'b1;
        case (ins[7:4])
          4'hA: begin t = {1'b0, a} + {1'b0, b}; res = t[15:0]; c = t[16]; end
          4'h2: begin res = a - b; c = (a >= b); end
          4'hC: res = a & b;
          4'hE: res = a | b;
          4'hD: res = a ^ b;
          4'hB: res = ~a;
          default: begin wr = 1'b0; ill = 1'b1; end
        endcase
      end
      4'h1: begin
        wr = 1'b1;
        b = {{8{ins[7]}}, ins[7:0]};
        t = {1'b0, a} + {1'b0, b};
        res = t[15:0];
        c = t[16];
      end
      4'h2: ;
      4'hF: hlt = 1'b1;
      default: ill = 1'b1;
    endcase
    if (ins[15:12] == 4'h2 && m_fl[0]) m_pc = ins[7:0];
    else if (!hlt) m_pc = m_pc + 8'h01;
    if (wr) begin
      m_r[rd] = res;
      m_fl = {res[15], c, (res == 16'h0)};
    end
    e = '{rd: rd, val: m_r[rd], fl: m_fl, pc: m_pc, ill: ill, hlt: hlt};
    sb.push_back(e);
  endtask

  task automatic wait_req_a();
    int n = 0;
    while (!req_a && n < 20) begin @(negedge CK); n++; end
    chk("a_fetch_wait", req_a, 1'b1);
  endtask

  // Fetch handshake with optional ack stall, then check the retired instruction.
  task automatic exec_a(input logic [15:0] ins, input int hold);
    exp_t       e;
    logic [7:0] a0;
    wait_req_a();
    a0 = addr_a;
    for (int i = 0; i < hold; i++) begin
      ack_a = 1'b0;
      data_a = 16'hF000;
      @(negedge CK);
      chk("stall_req", req_a, 1'b1);
      chk("stall_addr", addr_a, a0);
    end
    model(ins);
    ack_a = 1'b1;
    data_a = ins;
    @(negedge CK);
    ack_a = 1'b0;
    data_a = 16'hF000;
    chk("exec_req_low", req_a, 1'b0);
    @(negedge CK);
    e = sb.pop_front();
    chk("illegal_wb", ill_a, e.ill);
    @(negedge CK);
    sel_a = e.rd;
    #1;
    chk("rd_value", dbg_a, e.val);
    chk("flags", flags_a, e.fl);
    chk("halted", halt_a, e.hlt);
    chk("next_req", req_a, !e.hlt);
    chk("next_pc", addr_a, e.pc);
    chk("illegal_end", ill_a, 1'b0);
  endtask

  task automatic reset_a();
    rst_a = 1'b1;
    ack_a = 1'b0;
    @(negedge CK);
    @(negedge CK);
    rst_a = 1'b0;
    model_reset();
  endtask

  task automatic exec_b(input logic [15:0] ins);
    int n = 0;
    while (!req_b && n < 20) begin @(negedge CK); n++; end
    chk("b_fetch_wait", req_b, 1'b1);
    ack_b = 1'b1;
    data_b = ins;
    @(negedge CK);
    ack_b = 1'b0;
    data_b = 16'h0000;
    @(negedge CK);
    @(negedge CK);
  endtask

  initial begin
    rst_a = 1'b1; ack_a = 1'b0; data_a = 16'h0; sel_a = 4'h0;
    rst_b = 1'b1; ack_b = 1'b0; data_b = 16'h0; sel_b = 4'h0;

    // Reset state, sampled in the first cycle after release.
    reset_a();
    #1;
    chk("rst_req", req_a, 1'b1);
    chk("rst_addr", addr_a, 8'h00);
    chk("rst_flags", flags_a, 3'b000);
    chk("rst_illegal", ill_a, 1'b0);
    chk("rst_halted", halt_a, 1'b0);
    sel_a = 4'hF; #1;
    chk("rst_r15", dbg_a, 16'h0);

    exec_a(16'h1105, 0);
    exec_a(16'h1203, 0);
    exec_a(16'h01A2, 0);
    exec_a(16'h11FB, 0);
    exec_a(16'h0122, 0);
    exec_a(16'h2010, 0);
    exec_a(16'h11FF, 0);
    exec_a(16'h1101, 0);
    exec_a(16'h11FF, 5);
    exec_a(16'h2040, 0);
    exec_a(16'h135A, 0);
    exec_a(16'h03D2, 0);
    exec_a(16'h03E2, 0);
    exec_a(16'h03C2, 0);
    exec_a(16'h03B0, 0);
    exec_a(16'h0021, 0);
    exec_a(16'h7123, 0);
    exec_a(16'h0101, 0);
    exec_a(16'hF000, 0);
    for (int i = 0; i < 8; i++) begin
      ack_a = 1'b1;
      @(negedge CK);
      chk("halt_stay", halt_a, 1'b1);
      chk("halt_noreq", req_a, 1'b0);
    end
    ack_a = 1'b0;

    // Reset landing on the WB edge must drop the pending write.
    reset_a();
    exec_a(16'h1107, 0);
    wait_req_a();
    ack_a = 1'b1;
    data_a = 16'h1407;
    @(negedge CK);
    ack_a = 1'b0;
    @(negedge CK);
    rst_a = 1'b1;
    @(negedge CK);
    rst_a = 1'b0;
    model_reset();
    sel_a = 4'h4; #1;
    chk("abort_r4", dbg_a, 16'h0);
    chk("abort_req", req_a, 1'b1);
    chk("abort_addr", addr_a, 8'h00);
    exec_a(16'h1407, 0);

    // 32-bit datapath, 4-bit PC.
    @(negedge CK);
    rst_b = 1'b0;
    exec_b(16'h11FF);
    exec_b(16'h1201);
    exec_b(16'h01A2);
    sel_b = 4'h1; #1;
    chk("b_add_wrap", dbg_b, 32'h0);
    chk("b_flags", flags_b, 3'b011);
    chk("b_pc3", addr_b, 4'd3);
    for (int i = 0; i < 12; i++) exec_b(16'h7000);
    chk("b_pc15", addr_b, 4'd15);
    exec_b(16'h7000);
    chk("b_pc_wrap", addr_b, 4'd0);
    chk("b_req_wrap", req_b, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscomp);
    $finish;
  end

endmodule

// File: doc/my_cpu_core.md
MY_CPU_CORE -- requirements
Module: my_cpu_core

Interface
REQ-001 SHALL have parameter WIDTH, default 16: datapath and register width, legal range 8..64.
REQ-002 SHALL have parameter PC_W, default 8: program counter and instruction address width.
REQ-003 SHALL have port CK  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST  input  1: reset, synchronous and active-high.
REQ-005 SHALL have port imem_req  output  1: instruction fetch request.
REQ-006 SHALL have port imem_addr  output  PC_W: fetch address, equal to PC.
REQ-007 SHALL have port imem_ack  input  1: fetch data valid this cycle.
REQ-008 SHALL have port imem_data  input  16: instruction word.
REQ-009 SHALL have port dbg_sel  input  4: register index for debug read.
REQ-010 SHALL have port dbg_data  output  WIDTH: combinational read of register dbg_sel.
REQ-011 SHALL have port flags  output  3: registered {N, C, Z}.
REQ-012 SHALL have port illegal  output  1: one-cycle pulse on an undefined instruction.
REQ-013 SHALL have port halted  output  1: high while in HALT state.

Function
REQ-014 SHALL implement FSM states FETCH, EXEC, WB, HALT; reset enters FETCH.
REQ-015 FETCH SHALL drive imem_req=1 and imem_addr=PC; stay until imem_ack=1, then latch imem_data into IR and go to EXEC.
REQ-016 EXEC SHALL read rd=IR[11:8] and rs=IR[3:0] from a 16 x WIDTH register file, compute the result and flags into holding registers, then go to WB.
REQ-017 WB SHALL write result to rd (if writing), update flags (if flag-setting), set PC=PC+1 modulo 2^PC_W, and go to FETCH; minimum 3 cycles per instruction.
REQ-018 Opcode IR[15:12]=0000 ALU, func IR[7:4]: 1010 ADD rd=rd+rs; 0010 SUB rd=rd-rs; 1100 AND; 1110 OR; 1101 XOR; 1011 NOT rd=~rd; all write rd and flags.
REQ-019 Opcode 0001 ADDI: rd=rd+sign-extended IR[7:0] to WIDTH; writes rd and flags.
REQ-020 Opcode 0010 JZ: if Z=1, PC=zero-extended IR[7:0] (truncated to PC_W), else PC+1; no register or flag write.
REQ-021 Opcode 1111 HALT: enter HALT after WB without incrementing PC; stay until RST.
REQ-022 Any other opcode/func SHALL behave as NOP (PC+1) and pulse illegal=1 in its WB cycle.
REQ-023 Arithmetic SHALL be WIDTH bits modulo 2^WIDTH; C = carry-out for ADD/ADDI, C = NOT borrow (rd>=rs unsigned) for SUB, C=0 for logic ops; Z = result==0; N = result[WIDTH-1].
REQ-024 Register r0 SHALL be an ordinary writable register.
REQ-025 imem_data SHALL be ignored in any cycle where imem_req=0 or imem_ack=0.
REQ-026 dbg_data SHALL reflect a WB write from the cycle after that WB edge.

Reset
REQ-027 RST=1 at a clock edge SHALL set PC=0, state=FETCH, IR=0, flags=000, illegal=0, halted=0, all 16 registers to 0.
REQ-028 RST asserted mid-fetch or mid-instruction SHALL abandon it; no register write occurs at that edge; imem_req=1 with imem_addr=0 in the first cycle after RST deasserts.
REQ-029 RST SHALL take priority over imem_ack and all FSM transitions at the same edge.

Structure
REQ-030 Shared package SHALL hold state encoding, opcode constants (ALU, ADDI, JZ, HALT) and func constants (ADD, SUB, AND, OR, XOR, NOT).
REQ-031 A sub-module my_alu_p (parameter WIDTH; inputs a, b, func; outputs result, carry, valid-func) SHALL be the only arithmetic/logic logic; FSM, PC and register file stay in my_cpu_core.

Verification
REQ-032 WIDTH=16, ack same cycle: ADDI r1,5; ADDI r2,3; ADD r1,r2 -> r1=8, flags=000, each instruction 3 cycles.
REQ-033 r1=3, r2=3, SUB r1,r2 -> r1=0, Z=1, C=1; then JZ 0x10 -> next imem_addr=0x10.
REQ-034 WIDTH=16, r1=0xFFFF, ADDI r1,1 -> r1=0, C=1, Z=1; ADDI r1,-1 (0xFF) -> r1=0xFFFF, N=1.
REQ-035 imem_ack held low 5 cycles -> imem_req and imem_addr stable throughout, no state change; then ack -> instruction executes normally.
REQ-036 Opcode 0111 -> illegal pulses 1 cycle, no register/flag change, PC+1; HALT -> halted=1, imem_req=0 indefinitely; RST -> fetch from 0.
REQ-037 WIDTH=32, PC_W=4: PC at 15 executing NOP-class instruction wraps to 0; ADD of 0xFFFFFFFF+1 -> 0, C=1.
